// File: rtl/box_cache_pkg.sv
// rtl/box_cache_pkg.sv - shared constants, state encoding and line record for box_cache
package box_cache_pkg;

   localparam int LINES  = 8;
   localparam int IDX_W  = 3;
   localparam int BOX_W  = 8;
   localparam int DATA_W = 64;
   localparam int TAG_W  = BOX_W - IDX_W;

   typedef enum logic [3:0] {
      IDLE,
      LOOKUP,
      EVICT,
      EVICT_WAIT,
      FILL,
      FILL_WAIT,
      RESP,
      FLUSH_SCAN,
      FLUSH_WAIT
   } cache_state_t;

   typedef struct packed {
      logic              valid;
      logic              dirty;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } line_t;

   function automatic line_t make_line(input logic valid, input logic dirty,
                                       input logic [TAG_W-1:0] tag,
                                       input logic [DATA_W-1:0] data);
      line_t l;
      l.valid = valid;
      l.dirty = dirty;
      l.tag   = tag;
      l.data  = data;
      return l;
   endfunction

endpackage

// File: rtl/cache_tag_array.sv
// rtl/cache_tag_array.sv - direct-mapped line store, combinational read, one write port
module cache_tag_array
   import box_cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output line_t            rd_line,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  line_t            wr_line
);

   logic [LINES-1:0]  valid_q, valid_d;
   logic [LINES-1:0]  dirty_q, dirty_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [DATA_W-1:0] data_q [LINES];

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (we) begin
         valid_d[wr_idx] = wr_line.valid;
         dirty_d[wr_idx] = wr_line.dirty;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data are only meaningful under valid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[wr_idx]  <= wr_line.tag;
         data_q[wr_idx] <= wr_line.data;
      end
   end

   assign rd_line = make_line(valid_q[rd_idx], dirty_q[rd_idx], tag_q[rd_idx], data_q[rd_idx]);

endmodule

// File: rtl/box_cache.sv
// rtl/box_cache.sv - write-back direct-mapped box record cache between BEV and the DRAM bridge
module box_cache
   import box_cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              up_in_valid,
   input  logic              up_r_wb,
   input  logic [BOX_W-1:0]  up_addr,
   input  logic [DATA_W-1:0] up_data_w,
   output logic              up_out_valid,
   output logic [DATA_W-1:0] up_data_r,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              busy,
   output logic              C_in_valid,
   output logic              C_r_wb,
   output logic [BOX_W-1:0]  C_addr,
   output logic [DATA_W-1:0] C_data_w,
   input  logic              C_out_valid,
   input  logic [DATA_W-1:0] C_data_r
);

   localparam int PTR_W = IDX_W + 1;

   cache_state_t      state_q, state_d;
   logic              req_r_wb_q, req_r_wb_d;
   logic [BOX_W-1:0]  req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_data_q, req_data_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              c_r_wb_q, c_r_wb_d;
   logic [BOX_W-1:0]  c_addr_q, c_addr_d;
   logic [DATA_W-1:0] c_data_w_q, c_data_w_d;

   logic [IDX_W-1:0]  req_idx, rd_idx;
   logic [TAG_W-1:0]  req_tag;
   line_t             rd_line, wr_line;
   logic              we, hit, flushing;

   assign req_idx  = req_addr_q[IDX_W-1:0];
   assign req_tag  = req_addr_q[BOX_W-1:IDX_W];
   assign flushing = (state_q == FLUSH_SCAN) || (state_q == FLUSH_WAIT);
   assign rd_idx   = flushing ? ptr_q[IDX_W-1:0] : req_idx;
   assign hit      = rd_line.valid && (rd_line.tag == req_tag);

   cache_tag_array u_lines (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (rd_idx),
      .rd_line (rd_line),
      .we      (we),
      .wr_idx  (rd_idx),
      .wr_line (wr_line)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         req_r_wb_q <= 1'b0;
         req_addr_q <= '0;
         req_data_q <= '0;
         ptr_q      <= '0;
         c_r_wb_q   <= 1'b0;
         c_addr_q   <= '0;
         c_data_w_q <= '0;
      end else begin
         state_q    <= state_d;
         req_r_wb_q <= req_r_wb_d;
         req_addr_q <= req_addr_d;
         req_data_q <= req_data_d;
         ptr_q      <= ptr_d;
         c_r_wb_q   <= c_r_wb_d;
         c_addr_q   <= c_addr_d;
         c_data_w_q <= c_data_w_d;
      end
   end

   // Bridge fields come from the _d side so they are valid in the issue cycle and held afterwards.
   assign C_r_wb   = c_r_wb_d;
   assign C_addr   = c_addr_d;
   assign C_data_w = c_data_w_d;
   assign busy     = (state_q != IDLE);

   always_comb begin
      state_d      = state_q;
      req_r_wb_d   = req_r_wb_q;
      req_addr_d   = req_addr_q;
      req_data_d   = req_data_q;
      ptr_d        = ptr_q;
      c_r_wb_d     = c_r_wb_q;
      c_addr_d     = c_addr_q;
      c_data_w_d   = c_data_w_q;
      up_out_valid = 1'b0;
      up_data_r    = '0;
      flush_done   = 1'b0;
      C_in_valid   = 1'b0;
      we           = 1'b0;
      wr_line      = rd_line;

      unique case (state_q)
         IDLE: begin
            if (up_in_valid) begin
               req_r_wb_d = up_r_wb;
               req_addr_d = up_addr;
               req_data_d = up_data_w;
               state_d    = LOOKUP;
            end else if (flush_req) begin
               ptr_d   = '0;
               state_d = FLUSH_SCAN;
            end
         end
         LOOKUP: begin
            if (req_r_wb_q && hit) begin
               up_out_valid = 1'b1;
               up_data_r    = rd_line.data;
               state_d      = IDLE;
            end else if (!req_r_wb_q && (hit || !rd_line.valid || !rd_line.dirty)) begin
               we           = 1'b1;
               wr_line      = make_line(1'b1, 1'b1, req_tag, req_data_q);
               up_out_valid = 1'b1;
               state_d      = IDLE;
            end else if (rd_line.valid && rd_line.dirty) begin
               state_d = EVICT;
            end else begin
               state_d = FILL;
            end
         end
         EVICT: begin
            C_in_valid = 1'b1;
            c_r_wb_d   = 1'b0;
            c_addr_d   = {rd_line.tag, req_idx};
            c_data_w_d = rd_line.data;
            state_d    = EVICT_WAIT;
         end
         EVICT_WAIT: begin
            if (C_out_valid) begin
               we = 1'b1;
               if (!req_r_wb_q) begin
                  wr_line = make_line(1'b1, 1'b1, req_tag, req_data_q);
                  state_d = RESP;
               end else begin
                  wr_line.dirty = 1'b0;
                  state_d       = FILL;
               end
            end
         end
         FILL: begin
            C_in_valid = 1'b1;
            c_r_wb_d   = 1'b1;
            c_addr_d   = req_addr_q;
            state_d    = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (C_out_valid) begin
               we      = 1'b1;
               wr_line = make_line(1'b1, 1'b0, req_tag, C_data_r);
               state_d = RESP;
            end
         end
         RESP: begin
            up_out_valid = 1'b1;
            if (req_r_wb_q) up_data_r = rd_line.data;
            state_d = IDLE;
         end
         FLUSH_SCAN: begin
            // Pointer MSB set means every index has been visited.
            if (ptr_q[IDX_W]) begin
               flush_done = 1'b1;
               state_d    = IDLE;
            end else if (rd_line.valid && rd_line.dirty) begin
               C_in_valid = 1'b1;
               c_r_wb_d   = 1'b0;
               c_addr_d   = {rd_line.tag, ptr_q[IDX_W-1:0]};
               c_data_w_d = rd_line.data;
               state_d    = FLUSH_WAIT;
            end else begin
               ptr_d = ptr_q + PTR_W'(1);
            end
         end
         FLUSH_WAIT: begin
            if (C_out_valid) begin
               we            = 1'b1;
               wr_line.dirty = 1'b0;
               ptr_d         = ptr_q + PTR_W'(1);
               state_d       = FLUSH_SCAN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_box_cache.sv
// tb/tb_box_cache.sv - randomized self-checking bench for box_cache against a DRAM/cache reference model
module tb_box_cache;
   import box_cache_pkg::*;

   logic        clk, rst_n;
   logic        up_in_valid, up_r_wb, flush_req;
   logic [7:0]  up_addr;
   logic [63:0] up_data_w;
   logic        up_out_valid, flush_done, busy;
   logic [63:0] up_data_r;
   logic        C_in_valid, C_r_wb, C_out_valid;
   logic [7:0]  C_addr;
   logic [63:0] C_data_w, C_data_r;

   int n_checks, n_errors;
   bit hold_resp;

   logic [63:0] dram      [256];
   logic [63:0] mem_model [256];
   bit          m_valid   [8];
   bit          m_dirty   [8];
   logic [4:0]  m_tag     [8];

   logic [7:0]  bw_addr [$];
   logic [63:0] bw_data [$];
   logic [7:0]  br_addr [$];

   box_cache dut (
      .clk(clk), .rst_n(rst_n),
      .up_in_valid(up_in_valid), .up_r_wb(up_r_wb), .up_addr(up_addr), .up_data_w(up_data_w),
      .up_out_valid(up_out_valid), .up_data_r(up_data_r),
      .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
      .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr), .C_data_w(C_data_w),
      .C_out_valid(C_out_valid), .C_data_r(C_data_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Bridge / pseudo DRAM: random latency, single outstanding transaction.
   initial begin
      bit          pending;
      bit          p_rd;
      logic [7:0]  p_addr;
      logic [63:0] p_data;
      int          wait_cnt;
      pending = 0; p_rd = 0; p_addr = '0; p_data = '0; wait_cnt = 0;
      C_out_valid = 1'b0;
      C_data_r = '0;
      forever begin
         @(posedge clk); #1;
         C_out_valid = 1'b0;
         if (!rst_n) begin
            pending = 0;
         end else begin
            if (pending && !hold_resp) begin
               if (wait_cnt == 0) begin
                  C_out_valid = 1'b1;
                  if (p_rd) C_data_r = dram[p_addr];
                  else dram[p_addr] = p_data;
                  pending = 0;
               end else begin
                  wait_cnt--;
               end
            end
            if (C_in_valid) begin
               chk("one_outstanding", 64'(pending), 64'd0);
               pending  = 1;
               p_rd     = C_r_wb;
               p_addr   = C_addr;
               p_data   = C_data_w;
               wait_cnt = $urandom_range(0, 3);
               if (C_r_wb) br_addr.push_back(C_addr);
               else begin
                  bw_addr.push_back(C_addr);
                  bw_data.push_back(C_data_w);
               end
            end
         end
      end
   end

   task automatic do_req(input logic r_wb, input logic [7:0] addr, input logic [63:0] data, input bit inject);
      logic [2:0]  idx;
      logic [4:0]  tg;
      logic [7:0]  victim;
      logic [63:0] rdata;
      bit          hit, exp_w, exp_r, got;
      int          nw0, nr0, lat, extra;
      idx    = addr[2:0];
      tg     = addr[7:3];
      hit    = m_valid[idx] && (m_tag[idx] == tg);
      exp_w  = !hit && m_valid[idx] && m_dirty[idx];
      exp_r  = r_wb && !hit;
      victim = {m_tag[idx], idx};
      nw0    = bw_addr.size();
      nr0    = br_addr.size();
      rdata  = '0;
      got    = 0;
      extra  = 0;
      @(posedge clk); #1;
      chk("idle_busy", 64'(busy), 64'd0);
      up_in_valid = 1'b1; up_r_wb = r_wb; up_addr = addr; up_data_w = data;
      @(posedge clk); #1;
      up_in_valid = 1'b0;
      lat = 1;
      while (1) begin
         if (up_out_valid) begin
            got = 1;
            rdata = up_data_r;
            break;
         end
         if (lat >= 100) break;
         if (inject && lat == 2) begin
            up_in_valid = 1'b1; up_r_wb = 1'b1; up_addr = addr ^ 8'h80; flush_req = 1'b1;
         end
         @(posedge clk); #1;
         up_in_valid = 1'b0;
         flush_req = 1'b0;
         lat++;
      end
      chk("resp_seen", 64'(got), 64'd1);
      if (got) chk("busy_at_resp", 64'(busy), 64'd1);
      if (hit || (!r_wb && !exp_w)) chk("fast_latency", 64'(lat), 64'd1);
      if (r_wb) chk("read_data", rdata, mem_model[addr]);
      if (inject) begin
         repeat (3) begin
            @(posedge clk); #1;
            if (up_out_valid || C_in_valid) extra++;
         end
         chk("busy_ignored", 64'(extra), 64'd0);
      end
      chk("n_bridge_wr", 64'(bw_addr.size() - nw0), 64'(exp_w));
      chk("n_bridge_rd", 64'(br_addr.size() - nr0), 64'(exp_r));
      if (exp_w && bw_addr.size() > nw0) begin
         chk("evict_addr", bw_addr[nw0], victim);
         chk("evict_data", bw_data[nw0], mem_model[victim]);
      end
      if (exp_r && br_addr.size() > nr0) chk("fill_addr", br_addr[nr0], addr);
      if (!r_wb) begin
         mem_model[addr] = data;
         m_valid[idx] = 1; m_dirty[idx] = 1; m_tag[idx] = tg;
      end else if (!hit) begin
         m_valid[idx] = 1; m_dirty[idx] = 0; m_tag[idx] = tg;
      end
   endtask

   task automatic do_flush();
      logic [7:0] exp_q [$];
      int nw0, cyc;
      bit got;
      for (int i = 0; i < 8; i++)
         if (m_valid[i] && m_dirty[i]) exp_q.push_back({m_tag[i], 3'(i)});
      nw0 = bw_addr.size();
      got = 0;
      @(posedge clk); #1;
      chk("flush_idle_busy", 64'(busy), 64'd0);
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      cyc = 1;
      while (1) begin
         if (flush_done) begin
            got = 1;
            break;
         end
         if (cyc >= 400) break;
         @(posedge clk); #1;
         cyc++;
      end
      chk("flush_done_seen", 64'(got), 64'd1);
      @(posedge clk); #1;
      chk("flush_done_once", 64'(flush_done), 64'd0);
      chk("flush_n_wr", 64'(bw_addr.size() - nw0), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (nw0 + i < bw_addr.size()) begin
            chk("flush_wr_addr", bw_addr[nw0 + i], exp_q[i]);
            chk("flush_wr_data", bw_data[nw0 + i], mem_model[exp_q[i]]);
         end
      end
      if (exp_q.size() == 0) chk("flush_clean_latency", 64'(cyc), 64'd9);
      for (int i = 0; i < 8; i++) m_dirty[i] = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      bit seen;
      n_checks = 0; n_errors = 0; hold_resp = 0;
      rst_n = 1'b0; up_in_valid = 1'b0; up_r_wb = 1'b0; up_addr = '0; up_data_w = '0; flush_req = 1'b0;
      for (int b = 0; b < 256; b++) dram[b] = {$urandom, $urandom};
      dram[8'h12] = 64'h0123456789ABCDEF;
      for (int b = 0; b < 256; b++) mem_model[b] = dram[b];
      for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end

      #12;
      chk("rst_out_valid", 64'(up_out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_c_in_valid", 64'(C_in_valid), 64'd0);
      chk("rst_c_addr", 64'(C_addr), 64'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;

      do_req(1'b1, 8'h12, '0, 0);
      do_req(1'b1, 8'h12, '0, 0);
      do_req(1'b0, 8'h05, 64'hAAAAAAAAAAAAAAAA, 0);
      do_req(1'b1, 8'h05, '0, 0);
      do_req(1'b1, 8'h0D, '0, 0);
      chk("dram_05_written_back", dram[8'h05], 64'hAAAAAAAAAAAAAAAA);

      do_flush();
      do_req(1'b0, 8'h21, {$urandom, $urandom}, 0);
      do_req(1'b0, 8'h16, {$urandom, $urandom}, 0);
      do_flush();
      do_flush();

      do_req(1'b1, 8'h3A, '0, 1);

      // Reset while a fill is outstanding: outputs drop at once and the line is refetched.
      hold_resp = 1;
      n0 = br_addr.size();
      seen = 0;
      @(posedge clk); #1;
      up_in_valid = 1'b1; up_r_wb = 1'b1; up_addr = 8'hE3;
      @(posedge clk); #1;
      up_in_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (br_addr.size() > n0) begin
            seen = 1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("fill_before_reset", 64'(seen), 64'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(up_out_valid), 64'd0);
      chk("arst_data_r", up_data_r, 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_flush_done", 64'(flush_done), 64'd0);
      chk("arst_c_in_valid", 64'(C_in_valid), 64'd0);
      chk("arst_c_r_wb", 64'(C_r_wb), 64'd0);
      chk("arst_c_addr", 64'(C_addr), 64'd0);
      chk("arst_c_data_w", C_data_w, 64'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      hold_resp = 0;
      for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
      for (int b = 0; b < 256; b++) mem_model[b] = dram[b];
      do_req(1'b1, 8'hE3, '0, 0);

      for (int k = 0; k < 150; k++) begin
         logic [7:0] a;
         a = {3'b000, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
         if ($urandom_range(0, 9) == 0) do_flush();
         else do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, $urandom_range(0, 9) == 0);
      end

      do_flush();
      for (int b = 0; b < 256; b++) chk("dram_final", dram[b], mem_model[b]);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
